// File: rtl/ebi_pkg.sv
// rtl/ebi_pkg.sv - shared types and address decode for the EBI write dispatch path
package ebi_pkg;

   typedef enum logic [1:0] {TGT_VRAM, TGT_OAM, TGT_PALETTE, TGT_CTRL} target_t;

   localparam int TGT_MSB      = 15;
   localparam int TGT_LSB      = 14;
   localparam int LOCAL_ADDR_W = 14;

   typedef struct packed {
      target_t                 target;
      logic [LOCAL_ADDR_W-1:0] addr;
      logic [15:0]             data;
   } ebi_wr_t;

   // Upper address bits select the region, the rest is the word address inside it.
   function automatic ebi_wr_t decode(input logic [15:0] address, input logic [15:0] data);
      ebi_wr_t e;
      e.target = target_t'(address[TGT_MSB:TGT_LSB]);
      e.addr   = address[LOCAL_ADDR_W-1:0];
      e.data   = data;
      return e;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock register-array FIFO with occupancy counter
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (PTR_W+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ebi_write_dispatch.sv
// rtl/ebi_write_dispatch.sv - captures EBI writes, decodes region, drains via valid/ready
module ebi_write_dispatch
   import ebi_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        address_in,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     data_ready,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output target_t                  wr_target,
   output logic [LOCAL_ADDR_W-1:0]  wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);

   logic    data_ready_q;
   logic    push;
   logic    pop;
   logic    full;
   logic    empty;
   ebi_wr_t entry;
   ebi_wr_t head;

   // data_ready may be held for several cycles; only its rising edge is a new write.
   assign push  = data_ready && !data_ready_q;
   assign pop   = wr_valid && wr_ready;
   assign entry = decode(address_in, data_in);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_ready_q <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         data_ready_q <= data_ready;
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH ($bits(ebi_wr_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (entry),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   assign wr_valid  = !empty;
   assign wr_target = head.target;
   assign wr_addr   = head.addr;
   assign wr_data   = head.data;

endmodule

// File: tb/tb_ebi_write_dispatch.sv
// tb/tb_ebi_write_dispatch.sv - scoreboard bench for ebi_write_dispatch
module tb_ebi_write_dispatch;
   import ebi_pkg::*;

   localparam int DEPTH = 8;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [15:0]            address_in;
   logic [15:0]            data_in;
   logic                   data_ready;
   logic                   wr_valid;
   logic                   wr_ready;
   target_t                wr_target;
   logic [13:0]            wr_addr;
   logic [15:0]            wr_data;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   overflow;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q [$];
   logic [31:0] m_exp;
   logic [31:0] m_act;

   ebi_write_dispatch #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .address_in (address_in),
      .data_in    (data_in),
      .data_ready (data_ready),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_target  (wr_target),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Monitor: every handshake seen away from the edge is matched against the queue.
   always @(negedge clk) begin
      if (!reset && wr_valid && wr_ready) begin
         n_cmp++;
         m_act = {wr_target, wr_addr, wr_data};
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected: got %h, required no entry", m_act);
         end else begin
            m_exp = exp_q.pop_front();
            if (m_act !== m_exp) begin
               n_bad++;
               $display("FAIL pop_order: got tgt=%0d addr=%h data=%h, required tgt=%0d addr=%h data=%h",
                        m_act[31:30], m_act[29:16], m_act[15:0], m_exp[31:30], m_exp[29:16], m_exp[15:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [15:0] a, input logic [15:0] d, input int hold);
      address_in = a;
      data_in    = d;
      data_ready = 1'b1;
      repeat (hold) step();
      data_ready = 1'b0;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      data_ready = 1'b0;
      wr_ready   = 1'b0;
      address_in = '0;
      data_in    = '0;
      step();
      chk("reset_valid", 32'(wr_valid), 0);
      chk("reset_head", {wr_target, wr_addr, wr_data}, 0);
      chk("reset_level", 32'(fifo_level), 0);
      chk("reset_overflow", 32'(overflow), 0);
      step();
      reset = 1'b0;

      // 1: single write, data_ready held 3 cycles
      address_in = 16'h4005;
      data_in    = 16'h0032;
      data_ready = 1'b1;
      exp_q.push_back({2'd1, 14'h0005, 16'h0032});
      @(negedge clk);
      chk("t1_valid_before_edge", 32'(wr_valid), 0);
      step();
      @(negedge clk);
      chk("t1_valid_after_edge", 32'(wr_valid), 1);
      chk("t1_level", 32'(fifo_level), 1);
      chk("t1_target", 32'(wr_target), 1);
      chk("t1_addr", 32'(wr_addr), 32'h0005);
      chk("t1_data", 32'(wr_data), 32'h0032);
      step();
      step();
      data_ready = 1'b0;
      step();
      chk("t1_one_push_only", 32'(fifo_level), 1);
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      chk("t1_drained_valid", 32'(wr_valid), 0);

      // 2: backpressure and ordering
      exp_q.push_back({2'd0, 14'h0000, 16'd1});
      exp_q.push_back({2'd2, 14'h0010, 16'd2});
      exp_q.push_back({2'd3, 14'h03FF, 16'd3});
      pulse(16'h0000, 16'd1, 1);
      pulse(16'h8010, 16'd2, 1);
      pulse(16'hC3FF, 16'd3, 1);
      chk("t2_level", 32'(fifo_level), 3);
      chk("t2_head_stalled", {wr_target, wr_addr, wr_data}, {2'd0, 14'h0000, 16'd1});
      step();
      step();
      chk("t2_head_stable", {wr_target, wr_addr, wr_data}, {2'd0, 14'h0000, 16'd1});
      wr_ready = 1'b1;
      repeat (3) step();
      wr_ready = 1'b0;
      chk("t2_level_empty", 32'(fifo_level), 0);

      // 3: overflow, only the first DEPTH writes survive
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (i < DEPTH) exp_q.push_back({2'd0, 14'(i), 16'(16'h0100 + i)});
         pulse(16'(i), 16'(16'h0100 + i), 1);
         if (i == DEPTH - 1) chk("t3_no_overflow_at_full", 32'(overflow), 0);
         if (i == DEPTH) chk("t3_overflow_set", 32'(overflow), 1);
      end
      chk("t3_level_full", 32'(fifo_level), DEPTH);
      wr_ready = 1'b1;
      repeat (DEPTH + 2) step();
      wr_ready = 1'b0;
      chk("t3_level_drained", 32'(fifo_level), 0);
      chk("t3_queue_empty", 32'(exp_q.size()), 0);
      chk("t3_overflow_sticky", 32'(overflow), 1);

      // 4: push and pop together at full
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back({2'd3, 14'(i), 16'(16'h0A00 + i)});
         pulse(16'(16'hC000 + i), 16'(16'h0A00 + i), 1);
      end
      chk("t4_level_full", 32'(fifo_level), DEPTH);
      address_in = 16'h8123;
      data_in    = 16'hBEEF;
      exp_q.push_back({2'd2, 14'h0123, 16'hBEEF});
      data_ready = 1'b1;
      wr_ready   = 1'b1;
      step();
      data_ready = 1'b0;
      wr_ready   = 1'b0;
      chk("t4_level_held", 32'(fifo_level), DEPTH);
      chk("t4_no_overflow", 32'(overflow), 0);
      wr_ready = 1'b1;
      repeat (DEPTH + 2) step();
      wr_ready = 1'b0;
      chk("t4_level_drained", 32'(fifo_level), 0);
      chk("t4_queue_empty", 32'(exp_q.size()), 0);

      // 5: pointer wrap with random consumer stalls
      for (int i = 0; i < 3 * DEPTH; i++) begin
         logic [1:0]  tg;
         logic [13:0] la;
         tg = 2'(i);
         la = 14'(i * 3);
         exp_q.push_back({tg, la, 16'(i)});
         address_in = {tg, la};
         data_in    = 16'(i);
         data_ready = 1'b1;
         wr_ready   = ($urandom_range(0, 3) != 0);
         step();
         data_ready = 1'b0;
         wr_ready   = ($urandom_range(0, 3) != 0);
         step();
      end
      wr_ready = 1'b1;
      repeat (DEPTH + 2) step();
      wr_ready = 1'b0;
      chk("t5_level_final", 32'(fifo_level), 0);
      chk("t5_queue_empty", 32'(exp_q.size()), 0);
      chk("t5_no_overflow", 32'(overflow), 0);

      // 6: asynchronous reset with entries queued
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({2'd1, 14'(i), 16'(16'h0600 + i)});
         pulse(16'(16'h4000 + i), 16'(16'h0600 + i), 1);
      end
      chk("t6_level_before", 32'(fifo_level), 4);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_reset_valid", 32'(wr_valid), 0);
      chk("t6_reset_level", 32'(fifo_level), 0);
      chk("t6_reset_head", {wr_target, wr_addr, wr_data}, 0);
      exp_q.delete();
      address_in = 16'h4ABC;
      data_in    = 16'h5A5A;
      data_ready = 1'b1;
      exp_q.push_back({2'd1, 14'h0ABC, 16'h5A5A});
      step();
      reset = 1'b0;
      repeat (4) step();
      chk("t6_one_entry", 32'(fifo_level), 1);
      data_ready = 1'b0;
      step();
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      chk("t6_level_drained", 32'(fifo_level), 0);
      chk("final_queue_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
